// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with sub-word read-modify-write
module mem_access_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_address,
    output logic [31:0] dm_write_data,
    input  logic [31:0] dm_read_data
);

    typedef enum logic {IDLE, MERGE} state_t;

    localparam logic [32:0] BYTE_LIMIT = 33'(4 * MEM_WORDS);

    state_t      state, state_next;
    logic [31:0] cap_word;
    logic [31:0] cap_addr;
    logic [15:0] cap_data;
    logic        cap_half;
    logic        accept, active, err, do_access;
    logic        is_load, is_word_store, is_sub_store;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    // Request decode: an access is rejected when it is malformed, misaligned or out of range
    always_comb begin
        accept        = req_valid & (state == IDLE);
        active        = mem_read | mem_write;
        err           = (mem_read & mem_write)
                      | (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111)
                      | (((funct3 == 3'b001) | (funct3 == 3'b101)) & address[0])
                      | ((funct3 == 3'b010) & (address[1:0] != 2'b00))
                      | ({1'b0, address} >= BYTE_LIMIT);
        do_access     = accept & active & ~err;
        is_load       = do_access & mem_read;
        is_word_store = do_access & mem_write & (funct3[1:0] == 2'b10);
        is_sub_store  = do_access & mem_write & (funct3[1:0] != 2'b10);
    end

    // Load lane extraction from the combinational memory read
    always_comb begin
        lane_b = dm_read_data[{address[1:0], 3'b000} +: 8];
        lane_h = dm_read_data[{address[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'h0, lane_b};
            3'b101:  load_ext = {16'h0, lane_h};
            default: load_ext = dm_read_data;
        endcase
    end

    // Replace only the addressed byte/halfword of the captured word
    always_comb begin
        merged = cap_word;
        if (cap_half)
            merged[{cap_addr[1], 4'b0000} +: 16] = cap_data;
        else
            merged[{cap_addr[1:0], 3'b000} +: 8] = cap_data[7:0];
    end

    // Next-state and memory-port drive; reset silences the memory strobes
    always_comb begin
        state_next    = state;
        req_ready     = 1'b0;
        dm_read       = 1'b0;
        dm_write      = 1'b0;
        dm_address    = {address[31:2], 2'b00};
        dm_write_data = write_data;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                dm_read   = is_load | is_sub_store;
                dm_write  = is_word_store;
                if (is_sub_store)
                    state_next = MERGE;
            end
            MERGE: begin
                dm_address    = {cap_addr[31:2], 2'b00};
                dm_write      = 1'b1;
                dm_write_data = merged;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (rst) begin
            dm_read  = 1'b0;
            dm_write = 1'b0;
        end
    end

    // State register and registered load/error responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            load_data  <= 32'h0;
            load_valid <= 1'b0;
            access_err <= 1'b0;
        end else begin
            state      <= state_next;
            load_valid <= is_load;
            access_err <= accept & active & err;
            if (is_load)
                load_data <= load_ext;
        end
    end

    // Capture the old word and store operands for the merge cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_word <= 32'h0;
            cap_addr <= 32'h0;
            cap_data <= 16'h0;
            cap_half <= 1'b0;
        end else if (is_sub_store) begin
            cap_word <= dm_read_data;
            cap_addr <= address;
            cap_data <= write_data[15:0];
            cap_half <= funct3[0];
        end
    end

endmodule
